ag_mem_arbiter: RTL

AG_MEM_ARBITER -- requirements
Module: ag_mem_arbiter

---
 rtl/ag_mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ag_mem_arbiter.sv
// Shared-memory arbiter for CPU, video and DMA, one access per CYCLE_LEN baseclk periods.
// Define AG_ARB_FAIRNESS_EN so a CPU read that has stalled MAX_STALL cycles is ranked above DMA.
module ag_mem_arbiter #(
    parameter int CYCLE_LEN = 10,
    parameter int ACC_POS   = 5,
    parameter int MAX_STALL = 3
) (
    input  logic        baseclk,
    input  logic        rst,
    input  logic        cpu_req,
    input  logic        cpu_read,
    input  logic [15:0] cpu_ab,
    input  logic [7:0]  cpu_db_out,
    input  logic        vid_req,
    input  logic [15:0] vid_ab,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_ab,
    input  logic [7:0]  dma_dout,
    output logic [15:0] mem_ab,
    output logic [7:0]  mem_dout,
    output logic        mem_we,
    output logic        mem_en,
    input  logic [7:0]  mem_din,
    output logic [2:0]  gnt,
    output logic        cpu_rdy,
    output logic        vid_ack,
    output logic        dma_ack,
    output logic [7:0]  rd_data
);

    localparam int SW = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
    localparam logic [3:0]    LAST    = 4'(CYCLE_LEN - 1);
    localparam logic [3:0]    ACK_PRE = 4'(CYCLE_LEN - 2);
    localparam logic [3:0]    EN_PRE  = 4'(ACC_POS - 1);
    localparam logic [SW-1:0] STC_MAX = SW'(MAX_STALL);

    typedef enum logic [2:0] {
        OWN_NONE = 3'b000,
        OWN_CPU  = 3'b001,
        OWN_VID  = 3'b010,
        OWN_DMA  = 3'b100
    } owner_t;

    logic [3:0]    ctr;
    logic [SW-1:0] stc;
    owner_t        own_d;
    logic [2:0]    gnt_cur;
    logic          cpu_wr;
    logic          cpu_rd;
    logic          cpu_boost;

    always_comb begin
        cpu_wr = cpu_req && !cpu_read;
        cpu_rd = cpu_req && cpu_read;
`ifdef AG_ARB_FAIRNESS_EN
        cpu_boost = cpu_rd && (stc == STC_MAX);
`else
        cpu_boost = 1'b0;
`endif
        own_d = OWN_NONE;
        if (cpu_wr)
            own_d = OWN_CPU;
        else if (vid_req)
            own_d = OWN_VID;
        else if (cpu_boost)
            own_d = OWN_CPU;
        else if (dma_req)
            own_d = OWN_DMA;
        else if (cpu_rd)
            own_d = OWN_CPU;
        // mem_en for ACC_POS==1 is decided on the same edge that registers gnt
        gnt_cur = (ctr == '0) ? own_d : gnt;
    end

    always_ff @(posedge baseclk) begin
        if (!rst) begin
            ctr      <= '0;
            stc      <= '0;
            gnt      <= '0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_ab   <= '0;
            mem_dout <= '0;
            rd_data  <= '0;
            cpu_rdy  <= 1'b1;
            vid_ack  <= 1'b0;
            dma_ack  <= 1'b0;
        end else begin
            ctr     <= (ctr == LAST) ? '0 : ctr + 4'd1;
            mem_en  <= (ctr == EN_PRE) && (gnt_cur != '0);
            vid_ack <= (ctr == ACK_PRE) && gnt[1];
            dma_ack <= (ctr == ACK_PRE) && gnt[2];

            if (ctr == '0) begin
                gnt <= own_d;
                unique case (own_d)
                    OWN_CPU: begin
                        mem_ab   <= cpu_ab;
                        mem_we   <= cpu_wr;
                        mem_dout <= cpu_wr ? cpu_db_out : '0;
                    end
                    OWN_VID: begin
                        mem_ab   <= vid_ab;
                        mem_we   <= 1'b0;
                        mem_dout <= '0;
                    end
                    OWN_DMA: begin
                        mem_ab   <= dma_ab;
                        mem_we   <= dma_we;
                        mem_dout <= dma_we ? dma_dout : '0;
                    end
                    default: begin
                        mem_ab   <= '0;
                        mem_we   <= 1'b0;
                        mem_dout <= '0;
                    end
                endcase
                cpu_rdy <= !(cpu_rd && (own_d != OWN_CPU));
                // writes are always granted, so a denied request is always a read
                if (!cpu_req || (own_d == OWN_CPU))
                    stc <= '0;
                else if (stc != STC_MAX)
                    stc <= stc + 1'b1;
            end

            if ((ctr == LAST) && (gnt != '0) && !mem_we)
                rd_data <= mem_din;
        end
    end

endmodule
